multiphase_clock_divider: RTL and testbench

Runtime-programmable, multi-phase clock-enable generator for the SPWM datapath. It divides `clk_in` by a loadable divisor with a loadable high time. It drives `N_PH` phase-shifted square outputs, for example carrier/sample strobes for several inverter legs, plus a one-cycle period tick. New settings are double-buffered and applied only at a period boundary, so outputs never glitch or produce a truncated period.

---
 rtl/clk_div_pkg.sv | 16 +
 rtl/clk_div_phase_out.sv | 46 ++++
 rtl/multiphase_clock_divider.sv | 118 +++++++++++
 tb/tb_multiphase_clock_divider.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/clk_div_pkg.sv
// clk_div_pkg: shared constants and helpers for the multiphase clock divider.
//   CNT_W_DEFAULT   default width of divisor / high-time / phase fields
//   DEF_DIV_DEFAULT default divisor after reset (100 MHz -> 5 MHz)
//   MIN_DIV         smallest divisor a load may program
//   phase_lsb()     LSB position of channel k inside a packed phase vector
package clk_div_pkg;

    localparam int unsigned CNT_W_DEFAULT   = 16;
    localparam int unsigned DEF_DIV_DEFAULT = 20;
    localparam int unsigned MIN_DIV         = 2;

    function automatic int unsigned phase_lsb(input int unsigned k, input int unsigned w);
        return k * w;
    endfunction

endpackage

// File: rtl/clk_div_phase_out.sv
// clk_div_phase_out: one phase-shifted output channel.
//   clk_in   system clock
//   rst_n    asynchronous active-low reset
//   en       run enable; output forced low when 0
//   cnt      shared period counter
//   div_act  active divisor
//   high_act active high time
//   phase    this channel's phase offset (always < div_act)
//   clk_out  registered channel output
module clk_div_phase_out #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk_in,
    input  logic             rst_n,
    input  logic             en,
    input  logic [CNT_W-1:0] cnt,
    input  logic [CNT_W-1:0] div_act,
    input  logic [CNT_W-1:0] high_act,
    input  logic [CNT_W-1:0] phase,
    output logic             clk_out
);

    logic [CNT_W:0] diff;
    logic [CNT_W:0] pos;
    logic           out_d;

    // Position within the period: (cnt - phase) mod div_act, one extra bit
    // so the borrow is visible and the corrective add cannot overflow.
    always_comb begin
        diff = {1'b0, cnt} - {1'b0, phase};
        pos  = diff;
        if (diff[CNT_W]) begin
            pos = diff + {1'b0, div_act};
        end
        out_d = en && (pos < {1'b0, high_act});
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            clk_out <= 1'b0;
        end else begin
            clk_out <= out_d;
        end
    end

endmodule

// File: rtl/multiphase_clock_divider.sv
// multiphase_clock_divider: programmable divider producing N_PH phase-shifted
// square outputs plus a period tick. Settings are double-buffered and only
// take effect at a period boundary (or immediately while disabled).
//   clk_in   system clock          rst_n    async active-low reset
//   en       run enable            load     capture strobe for the inputs below
//   div_in   period (cycles)       high_in  high time (cycles)
//   phase_in packed phase offsets  clk_out  phase outputs
//   tick     period-start pulse    pending  shadow waiting for a boundary
//   err      rejected-load pulse
module multiphase_clock_divider
    import clk_div_pkg::*;
#(
    parameter int unsigned CNT_W   = CNT_W_DEFAULT,
    parameter int unsigned N_PH    = 3,
    parameter int unsigned DEF_DIV = DEF_DIV_DEFAULT
) (
    input  logic                  clk_in,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic                  load,
    input  logic [CNT_W-1:0]      div_in,
    input  logic [CNT_W-1:0]      high_in,
    input  logic [N_PH*CNT_W-1:0] phase_in,
    output logic [N_PH-1:0]       clk_out,
    output logic                  tick,
    output logic                  pending,
    output logic                  err
);

    localparam logic [CNT_W-1:0] RstDiv  = CNT_W'(DEF_DIV);
    localparam logic [CNT_W-1:0] RstHigh = CNT_W'(DEF_DIV / 2);

    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [CNT_W-1:0]      div_act_q, high_act_q;
    logic [N_PH*CNT_W-1:0] ph_act_q;
    logic [CNT_W-1:0]      div_sh_q, high_sh_q;
    logic [N_PH*CNT_W-1:0] ph_sh_q;
    logic                  pending_q, pending_d;
    logic                  tick_q, err_q;
    logic                  load_ok, wrap, apply;

    always_comb begin
        load_ok = (div_in >= CNT_W'(MIN_DIV)) && (high_in <= div_in);
        for (int unsigned k = 0; k < N_PH; k++) begin
            if (phase_in[phase_lsb(k, CNT_W) +: CNT_W] >= div_in) begin
                load_ok = 1'b0;
            end
        end
        wrap = en && (cnt_q == div_act_q - CNT_W'(1));
        // While disabled there is no period in flight, so a pending shadow
        // can be applied right away.
        apply = pending_q && (wrap || !en);

        cnt_d = cnt_q + CNT_W'(1);
        if (!en || wrap) begin
            cnt_d = '0;
        end

        // A load coinciding with an apply re-arms pending for the next boundary.
        pending_d = pending_q;
        if (apply) begin
            pending_d = 1'b0;
        end
        if (load && load_ok) begin
            pending_d = 1'b1;
        end
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q      <= '0;
            div_act_q  <= RstDiv;
            high_act_q <= RstHigh;
            ph_act_q   <= '0;
            div_sh_q   <= RstDiv;
            high_sh_q  <= RstHigh;
            ph_sh_q    <= '0;
            pending_q  <= 1'b0;
            tick_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            pending_q <= pending_d;
            tick_q    <= wrap;
            err_q     <= load && !load_ok;
            if (apply) begin
                div_act_q  <= div_sh_q;
                high_act_q <= high_sh_q;
                ph_act_q   <= ph_sh_q;
            end
            if (load && load_ok) begin
                div_sh_q  <= div_in;
                high_sh_q <= high_in;
                ph_sh_q   <= phase_in;
            end
        end
    end

    for (genvar k = 0; k < N_PH; k++) begin : g_phase
        clk_div_phase_out #(
            .CNT_W (CNT_W)
        ) u_phase_out (
            .clk_in   (clk_in),
            .rst_n    (rst_n),
            .en       (en),
            .cnt      (cnt_q),
            .div_act  (div_act_q),
            .high_act (high_act_q),
            .phase    (ph_act_q[phase_lsb(k, CNT_W) +: CNT_W]),
            .clk_out  (clk_out[k])
        );
    end

    assign tick    = tick_q;
    assign pending = pending_q;
    assign err     = err_q;

endmodule

// File: tb/tb_multiphase_clock_divider.sv
// Scoreboard bench for multiphase_clock_divider: the driver applies one input
// set per cycle, steps a reference model and queues the expected outputs; an
// independent monitor pops and compares them after every rising edge.
module tb_multiphase_clock_divider;

    localparam int unsigned CNT_W = 16;
    localparam int unsigned N_PH  = 3;

    logic                  clk_in = 1'b0;
    logic                  rst_n;
    logic                  en;
    logic                  load;
    logic [CNT_W-1:0]      div_in;
    logic [CNT_W-1:0]      high_in;
    logic [N_PH*CNT_W-1:0] phase_in;
    logic [N_PH-1:0]       clk_out;
    logic                  tick;
    logic                  pending;
    logic                  err;

    multiphase_clock_divider #(
        .CNT_W   (CNT_W),
        .N_PH    (N_PH),
        .DEF_DIV (20)
    ) dut (
        .clk_in   (clk_in),
        .rst_n    (rst_n),
        .en       (en),
        .load     (load),
        .div_in   (div_in),
        .high_in  (high_in),
        .phase_in (phase_in),
        .clk_out  (clk_out),
        .tick     (tick),
        .pending  (pending),
        .err      (err)
    );

    always #5 clk_in = ~clk_in;

    typedef struct packed {
        logic [N_PH-1:0] clk_out;
        logic            tick;
        logic            pending;
        logic            err;
    } exp_t;

    exp_t q[$];
    int   vectors    = 0;
    int   miscompares = 0;

    // Reference model: active and shadow settings plus the period position.
    int unsigned m_cnt, m_div, m_high;
    int unsigned m_ph[N_PH];
    int unsigned s_div, s_high;
    int unsigned s_ph[N_PH];
    bit          m_pend;

    task automatic model_reset();
        m_cnt  = 0;
        m_div  = 20;
        m_high = 10;
        s_div  = 20;
        s_high = 10;
        for (int k = 0; k < N_PH; k++) begin
            m_ph[k] = 0;
            s_ph[k] = 0;
        end
        m_pend = 1'b0;
    endtask

    task automatic push_zero();
        exp_t z;
        z = '0;
        q.push_back(z);
    endtask

    // Drive this cycle's inputs and predict what the DUT shows after the edge.
    task automatic step_now(input bit en_v, input bit ld, input int unsigned d,
                            input int unsigned h, input int unsigned p0,
                            input int unsigned p1, input int unsigned p2);
        int unsigned ph[N_PH];
        bit          ok, wrap, apply;
        exp_t        x;
        ph[0] = p0;
        ph[1] = p1;
        ph[2] = p2;
        en       = en_v;
        load     = ld;
        div_in   = CNT_W'(d);
        high_in  = CNT_W'(h);
        phase_in = {CNT_W'(p2), CNT_W'(p1), CNT_W'(p0)};

        ok = ld && (d >= 2) && (h <= d);
        for (int k = 0; k < N_PH; k++) begin
            if (ph[k] >= d) ok = 1'b0;
        end
        wrap = en_v && (m_cnt == m_div - 1);
        x = '0;
        for (int k = 0; k < N_PH; k++) begin
            x.clk_out[k] = en_v && (((m_cnt + m_div - m_ph[k]) % m_div) < m_high);
        end
        x.tick = wrap;
        x.err  = ld && !ok;
        apply  = m_pend && (wrap || !en_v);
        m_cnt  = (en_v && !wrap) ? m_cnt + 1 : 0;
        if (apply) begin
            m_div  = s_div;
            m_high = s_high;
            for (int k = 0; k < N_PH; k++) m_ph[k] = s_ph[k];
            m_pend = 1'b0;
        end
        if (ok) begin
            s_div  = d;
            s_high = h;
            for (int k = 0; k < N_PH; k++) s_ph[k] = ph[k];
            m_pend = 1'b1;
        end
        x.pending = m_pend;
        q.push_back(x);
    endtask

    task automatic drive(input bit en_v, input bit ld, input int unsigned d,
                         input int unsigned h, input int unsigned p0,
                         input int unsigned p1, input int unsigned p2);
        @(negedge clk_in);
        step_now(en_v, ld, d, h, p0, p1, p2);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b1, 1'b0, 0, 0, 0, 0, 0);
    endtask

    // Mid-run reset: outputs must drop without waiting for a clock edge.
    task automatic do_reset();
        @(negedge clk_in);
        rst_n = 1'b0;
        en    = 1'b0;
        load  = 1'b0;
        #1;
        vectors++;
        if ({clk_out, tick, pending, err} !== '0) begin
            miscompares++;
            $display("FAIL async_reset t=%0t got clk_out=%b tick=%b pending=%b err=%b want all 0",
                     $time, clk_out, tick, pending, err);
        end
        model_reset();
        push_zero();
        @(negedge clk_in);
        push_zero();
        @(negedge clk_in);
        rst_n = 1'b1;
        step_now(1'b0, 1'b0, 0, 0, 0, 0, 0);
    endtask

    // Monitor: the DUT presents outputs every cycle; compare after each edge.
    initial begin
        forever begin
            @(posedge clk_in);
            #1;
            if (q.size() != 0) begin
                exp_t x;
                x = q.pop_front();
                vectors++;
                if ({clk_out, tick, pending, err} !== x) begin
                    miscompares++;
                    $display("FAIL cycle t=%0t got clk_out=%b tick=%b pending=%b err=%b want clk_out=%b tick=%b pending=%b err=%b",
                             $time, clk_out, tick, pending, err,
                             x.clk_out, x.tick, x.pending, x.err);
                end
            end
        end
    end

    initial begin
        int          guard;
        int unsigned d, h;
        rst_n    = 1'b0;
        en       = 1'b0;
        load     = 1'b0;
        div_in   = '0;
        high_in  = '0;
        phase_in = '0;
        model_reset();
        for (int i = 0; i < 3; i++) begin
            push_zero();
            @(negedge clk_in);
        end
        rst_n = 1'b1;
        step_now(1'b0, 1'b0, 0, 0, 0, 0, 0);

        // Default 20-cycle period, 10 high, all channels in phase.
        idle(65);

        // Mid-period load of div=8 high=2 phases {0,3,5}.
        drive(1'b1, 1'b1, 8, 2, 0, 3, 5);
        idle(40);

        // Rejected loads.
        drive(1'b1, 1'b1, 1, 0, 0, 0, 0);
        idle(3);
        drive(1'b1, 1'b1, 6, 7, 0, 0, 0);
        idle(3);
        drive(1'b1, 1'b1, 6, 2, 0, 6, 0);
        idle(12);

        // Loads one cycle before the wrap and exactly at the wrap.
        guard = 0;
        while (m_cnt != m_div - 2 && guard < 100) begin
            idle(1);
            guard++;
        end
        drive(1'b1, 1'b1, 4, 1, 0, 1, 2);
        drive(1'b1, 1'b1, 10, 3, 0, 4, 9);
        idle(40);

        // Constant-low and constant-high outputs.
        drive(1'b1, 1'b1, 6, 0, 0, 2, 4);
        idle(20);
        drive(1'b1, 1'b1, 6, 6, 0, 2, 4);
        idle(20);

        // Reset mid-period, then drop en mid-period with a load while disabled.
        drive(1'b1, 1'b1, 12, 6, 0, 3, 6);
        idle(30);
        do_reset();
        idle(25);
        for (int i = 0; i < 4; i++) drive(1'b0, 1'b0, 0, 0, 0, 0, 0);
        drive(1'b0, 1'b1, 5, 2, 0, 1, 4);
        drive(1'b0, 1'b0, 0, 0, 0, 0, 0);
        idle(20);

        // Randomised traffic with small divisors, including invalid loads.
        for (int i = 0; i < 3000; i++) begin
            d = $urandom_range(12, 0);
            h = $urandom_range(d + 1, 0);
            drive(($urandom_range(9, 0) != 0), ($urandom_range(11, 0) == 0), d, h,
                  $urandom_range(d, 0), $urandom_range(d, 0), $urandom_range(d, 0));
            if (i == 1500) do_reset();
        end
        idle(5);

        guard = 0;
        while (q.size() != 0 && guard < 10) begin
            @(posedge clk_in);
            guard++;
        end
        #2;
        if (q.size() != 0) begin
            miscompares++;
            $display("FAIL drain got %0d queued want 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
